// File: rtl/average_pool_engine.sv
// rtl/average_pool_engine.sv - global average pooling over CH channels of 2^N_LOG2 activations
// Reads each channel from the feature buffer, writes one rounded mean per channel, then pulses finish.
module average_pool_engine #(
    parameter int DATA_W    = 8,
    parameter int N_LOG2    = 6,
    parameter int CH        = 4,
    parameter int RD_ADDR_W = 8,
    parameter int WR_ADDR_W = 5,
    parameter int OPC_BASE  = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_startAve,
    input  logic [5:0]           i_opcode,
    output logic                 o_rdEn,
    output logic [RD_ADDR_W-1:0] o_rdAddr,
    input  logic [DATA_W-1:0]    i_rdData,
    output logic                 o_wrEn,
    output logic [WR_ADDR_W-1:0] o_wrAddr,
    output logic [DATA_W-1:0]    o_wrData,
    output logic                 o_busy,
    output logic                 o_finish_ave
);

    localparam int ACC_W = DATA_W + N_LOG2;
    localparam int N     = 1 << N_LOG2;
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LAST,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [5:0]                opc_q, opc_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic [N_LOG2-1:0]         idx_q, idx_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      rd_vld_q;
    logic signed [ACC_W:0]     rnd_sum;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_startAve) state_d = S_READ;
            S_READ:  if (idx_q == N_LOG2'(N - 1)) state_d = S_LAST;
            S_LAST:  state_d = S_WRITE;
            S_WRITE: state_d = (ch_q == CH_W'(CH - 1)) ? S_DONE : S_READ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read data lags the strobe by one cycle, so accumulation follows the registered strobe.
    always_comb begin
        opc_d = opc_q;
        ch_d  = ch_q;
        idx_d = idx_q;
        acc_d = acc_q;
        if (rd_vld_q) begin
            acc_d = acc_q + {{N_LOG2{i_rdData[DATA_W-1]}}, i_rdData};
        end
        case (state_q)
            S_IDLE: begin
                if (i_startAve) begin
                    opc_d = i_opcode;
                    ch_d  = '0;
                    idx_d = '0;
                    acc_d = '0;
                end
            end
            S_READ: idx_d = idx_q + 1'b1;
            S_WRITE: begin
                idx_d = '0;
                acc_d = '0;
                if (ch_q != CH_W'(CH - 1)) begin
                    ch_d = ch_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            opc_q    <= '0;
            ch_q     <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            opc_q    <= opc_d;
            ch_q     <= ch_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            rd_vld_q <= (state_q == S_READ);
        end
    end

    // Round half up: add N/2 before the arithmetic shift; the sum fits with one guard bit.
    assign rnd_sum = {acc_q[ACC_W-1], acc_q} + $signed((ACC_W + 1)'(N / 2));

    always_comb begin
        o_rdEn       = 1'b0;
        o_rdAddr     = '0;
        o_wrEn       = 1'b0;
        o_wrAddr     = '0;
        o_wrData     = '0;
        o_finish_ave = 1'b0;
        o_busy       = (state_q != S_IDLE);
        case (state_q)
            S_READ: begin
                o_rdEn   = 1'b1;
                o_rdAddr = RD_ADDR_W'({ch_q, idx_q});
            end
            S_WRITE: begin
                o_wrEn   = 1'b1;
                o_wrAddr = WR_ADDR_W'((32'(opc_q) - 32'(OPC_BASE)) * 32'(CH) + 32'(ch_q));
                o_wrData = DATA_W'(rnd_sum >>> N_LOG2);
            end
            S_DONE:  o_finish_ave = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_average_pool_engine.sv
// tb/tb_average_pool_engine.sv - randomized self-checking bench for average_pool_engine
module tb_average_pool_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] opcode;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       finish;

    int errors = 0;
    int checks = 0;
    int mem [256];

    average_pool_engine dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_startAve   (start),
        .i_opcode     (opcode),
        .o_rdEn       (rd_en),
        .o_rdAddr     (rd_addr),
        .i_rdData     (rd_data),
        .o_wrEn       (wr_en),
        .o_wrAddr     (wr_addr),
        .o_wrData     (wr_data),
        .o_busy       (busy),
        .o_finish_ave (finish)
    );

    always #5 clk = ~clk;

    // Feature buffer: one-cycle read latency, garbage when not strobed.
    always @(posedge clk) rd_data <= rd_en ? 8'(mem[rd_addr]) : 8'($urandom);

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_mean(input int c);
        int sum, num, q;
        sum = 0;
        for (int i = 0; i < 64; i++) sum += mem[c * 64 + i];
        num = sum + 32;
        q = num / 64;
        if (num < 0 && (num % 64) != 0) q = q - 1;
        return q;
    endfunction

    function automatic int ref_addr(input int opc, input int c);
        int a;
        a = (opc - 32) * 4 + c;
        return ((a % 32) + 32) % 32;
    endfunction

    task automatic fill_random(input int mode);
        for (int i = 0; i < 256; i++) begin
            if (mode == 0) mem[i] = int'($urandom_range(0, 255)) - 128;
            else           mem[i] = int'($urandom_range(0, 4)) - 2;
        end
    endtask

    // Called at a negedge; returns at the negedge after the finish cycle.
    task automatic run_op(input int opc, input bit busy_start);
        int wa[$];
        int wd[$];
        int fin_k, exp_rd, rd_bad, overlap;
        fin_k = 0; exp_rd = 0; rd_bad = 0; overlap = 0;
        start = 1'b1;
        opcode = 6'(opc);
        @(posedge clk);
        #1;
        start = 1'b0;
        opcode = 6'($urandom);
        for (int k = 1; k <= 400 && fin_k == 0; k++) begin
            @(negedge clk);
            if (busy_start) begin
                if (k == 100) begin
                    start = 1'b1;
                    opcode = 6'd33;
                end else begin
                    start = 1'b0;
                end
            end
            if (rd_en) begin
                if (rd_addr != 8'(exp_rd)) rd_bad++;
                exp_rd++;
            end
            if (rd_en && wr_en) overlap++;
            if (wr_en) begin
                wa.push_back(int'(wr_addr));
                wd.push_back(int'($signed(wr_data)));
            end
            if (finish) fin_k = k;
        end
        start = 1'b0;
        check($sformatf("finish_cycle opc%0d", opc), fin_k, 265);
        check($sformatf("write_count opc%0d", opc), wa.size(), 4);
        for (int c = 0; c < 4; c++) begin
            if (c < wa.size()) begin
                check($sformatf("wr_addr opc%0d ch%0d", opc, c), wa[c], ref_addr(opc, c));
                check($sformatf("wr_data opc%0d ch%0d", opc, c), wd[c], ref_mean(c));
            end
        end
        check($sformatf("rd_addr_sweep opc%0d", opc), rd_bad, 0);
        check($sformatf("rd_count opc%0d", opc), exp_rd, 256);
        check($sformatf("rd_wr_overlap opc%0d", opc), overlap, 0);
        @(negedge clk);
        check($sformatf("finish_width opc%0d", opc), finish, 0);
        check($sformatf("idle_after opc%0d", opc), busy, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " rdEn"}, rd_en, 0);
        check({tag, " rdAddr"}, rd_addr, 0);
        check({tag, " wrEn"}, wr_en, 0);
        check({tag, " wrAddr"}, wr_addr, 0);
        check({tag, " wrData"}, wr_data, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " finish"}, finish, 0);
    endtask

    initial begin
        int late_writes, late_finish;
        rst_n = 1'b0;
        start = 1'b0;
        opcode = '0;
        for (int i = 0; i < 256; i++) mem[i] = 0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 256; i++) mem[i] = 1;
        run_op(32, 1'b0);

        for (int i = 0; i < 64; i++) begin
            mem[i]       = (i < 32) ? 1 : 0;
            mem[64 + i]  = (i < 32) ? -1 : 0;
            mem[128 + i] = (i < 33) ? -1 : 0;
            mem[192 + i] = -128;
        end
        run_op(32, 1'b0);

        for (int i = 0; i < 256; i++) mem[i] = 127;
        run_op(37, 1'b0);

        fill_random(0);
        run_op(32, 1'b1);

        fill_random(1);
        start = 1'b1;
        opcode = 6'd34;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k < 70; k++) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        late_writes = 0;
        late_finish = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (wr_en) late_writes++;
            if (finish) late_finish++;
        end
        check("writes_after_reset", late_writes, 0);
        check("finish_after_reset", late_finish, 0);
        fill_random(0);
        run_op(35, 1'b0);

        for (int opc = 32; opc <= 37; opc++) begin
            fill_random(opc % 2);
            run_op(opc, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/average_pool_engine.md
# average_pool_engine

Global-average-pooling responder for the MobileNet datapath. It serves the master controller's average start/finish handshake. On each start pulse it streams CH channels of 2^N_LOG2 signed activations from the feature buffer. For each channel it writes one rounded mean to the pooled-vector memory. It then returns a one-cycle finish pulse, which the controller consumes before advancing its opcode (averages run on opcodes 32..37).

## Interface
- DATA_W, 8, activation/result width (signed two's complement)
- N_LOG2, 6, log2 of elements per channel (N = 64)
- CH, 4, channels processed per start
- RD_ADDR_W, 8, feature-buffer address width (≥ log2(CH·N))
- WR_ADDR_W, 5, pooled-memory address width (≥ log2(6·CH))
- OPC_BASE, 32, opcode mapped to pooled-memory block 0
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_startAve  in  1  one-cycle start pulse from master control
- i_opcode  in  6  controller opcode, sampled with i_startAve
- o_rdEn  out  1  feature-buffer read strobe
- o_rdAddr  out  RD_ADDR_W  read address = ch·N + idx
- i_rdData  in  DATA_W  read data, valid exactly 1 cycle after o_rdEn
- o_wrEn  out  1  pooled-memory write strobe
- o_wrAddr  out  WR_ADDR_W  (opc − OPC_BASE)·CH + ch, modulo 2^WR_ADDR_W
- o_wrData  out  DATA_W  rounded channel mean
- o_busy  out  1  high in every state except IDLE
- o_finish_ave  out  1  one-cycle completion pulse

## Operation
- States: IDLE, READ, LAST, WRITE, DONE.
- IDLE:
  - Sample i_startAve.
  - On start: capture i_opcode → opc, clear ch, idx and acc, go to READ.
- READ:
  - o_rdEn=1, o_rdAddr = ch·N + idx; idx increments each cycle.
  - A registered copy of o_rdEn marks i_rdData valid; when marked, acc += sign-extended i_rdData.
  - After idx = N−1 is issued, go to LAST.
- LAST:
  - o_rdEn=0; accumulate the final sample.
  - Go to WRITE.
- WRITE:
  - o_wrEn=1, o_wrData = (acc + 2^(N_LOG2−1)) >>> N_LOG2, truncated to DATA_W.
  - Range is guaranteed within [−2^(DATA_W−1), 2^(DATA_W−1)−1], so no saturation is needed.
  - If ch = CH−1, go to DONE; else ch++, idx=0, acc=0, go to READ.
- DONE:
  - o_finish_ave=1 for one cycle, then IDLE.
- acc width is DATA_W+N_LOG2 (14 bits default), signed.
- i_startAve while o_busy=1 is ignored; no queuing.
- i_opcode changes after the start cycle have no effect.
- Reset (any cycle, including mid-channel):
  - State → IDLE; ch, idx, acc, opc → 0.
  - All outputs 0; no finish pulse and no further writes.

## Timing
- Start sampled at edge E0; cycle k means the cycle following E0+k−1.
- Per channel: N READ cycles + LAST + WRITE = N+2 cycles.
- Channel c timing:
  - READ cycles 1+c(N+2) .. N+c(N+2).
  - LAST cycle N+1+c(N+2); WRITE cycle N+2+c(N+2).
- o_finish_ave high in cycle CH(N+2)+1: 265 with defaults.
- Next start is accepted in the cycle after the finish pulse (IDLE).
- Back-to-back minimum period is therefore CH(N+2)+2 cycles.
- o_rdEn and o_wrEn are never high in the same cycle.
- Exactly CH writes per start.
- Reset values: o_rdEn=0, o_rdAddr=0, o_wrEn=0, o_wrAddr=0, o_wrData=0, o_busy=0, o_finish_ave=0.

## Test plan
- All-ones:
  - Buffer all = 1, opcode 32 → 4 writes of 1 to addr 0..3.
  - finish at cycle 265, exactly one cycle wide.
- Rounding:
  - ch0 holds 32×1 and 32×0 (sum 32, mean 0.5) → 1.
  - ch1 holds sum −32 → 0.
  - ch2 holds sum −33 → −1.
  - ch3 holds all −128 → −128.
- Extremes and address mapping:
  - All 127, opcode 37 → writes of 127 to addr 20..23.
  - o_rdAddr sweeps 0..255 contiguously.
- Start during busy:
  - Second i_startAve at cycle 100 with opcode 33 is ignored.
  - Still 4 writes to addr 0..3; finish at 265.
- Reset mid-operation:
  - Assert i_reset low at cycle 70 (ch1 READ).
  - All outputs 0 immediately; no write or finish afterwards.
  - A new start after release gives a full, correct 265-cycle run.
- Controller loop:
  - Six starts with opcode 32..37, each issued the cycle after the previous finish.
  - 24 writes to addr 0..23, in order.
